// File: rtl/b_bop_iter.sv
// ---------------------------------------------------------------------------
// b_bop_iter -- iterative sequencer around the bitwise ternary-LUT operator.
//
// b_bop (combinational):
//   rd, rs1, rs2 : XLEN-bit operands
//   lut          : 8-bit truth table; result[i] = lut[{rd[i], rs1[i], rs2[i]}]
//   result       : XLEN-bit output
//
// b_bop_iter (sequential):
//   clock, reset : single clock, asynchronous active-high reset
//   flush        : synchronous kill of any in-flight operation
//   req_*        : request port (valid/ready), operands, lut and count N
//   rsp_*        : response port (valid/ready) carrying the final accumulator
//   busy         : high whenever the sequencer is not idle
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and its payload until that edge; ready may
// change freely. rsp_result is held stable while rsp_valid && !rsp_ready.
//
// Operation: on accept, acc takes bop(req_rd, rs1, rs2, lut) (or req_rd when
// N == 0); every further cycle applies acc <= bop(acc, rs1, rs2, lut) until N
// applications are done, then the accumulator is presented on the response.
// ---------------------------------------------------------------------------

module b_bop #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rd,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [7:0]      lut,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = '0;
        for (int i = 0; i < XLEN; i++) begin
            result[i] = lut[{rd[i], rs1[i], rs2[i]}];
        end
    end

endmodule

module b_bop_iter #(
    parameter int XLEN = 32,
    parameter int CW   = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_rd,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [7:0]      req_lut,
    input  logic [CW-1:0]   req_count,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Current FSM state; kept as a named signal so checkers can bind to it.
    state_t state;
    state_t state_n;

    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] acc_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [7:0]      lut_q;
    logic            latch_ops;

    logic [XLEN-1:0] bop_rd;
    logic [XLEN-1:0] bop_rs1;
    logic [XLEN-1:0] bop_rs2;
    logic [7:0]      bop_lut;
    logic [XLEN-1:0] bop_out;

    // In IDLE the operator sees the live request so the accepting edge already
    // performs the first application; afterwards it sees acc and the latched
    // operands.
    assign bop_rd  = (state == IDLE) ? req_rd  : acc;
    assign bop_rs1 = (state == IDLE) ? req_rs1 : rs1_q;
    assign bop_rs2 = (state == IDLE) ? req_rs2 : rs2_q;
    assign bop_lut = (state == IDLE) ? req_lut : lut_q;

    b_bop #(
        .XLEN (XLEN)
    ) u_bop (
        .rd     (bop_rd),
        .rs1    (bop_rs1),
        .rs2    (bop_rs2),
        .lut    (bop_lut),
        .result (bop_out)
    );

    always_comb begin
        state_n   = state;
        acc_n     = acc;
        cnt_n     = cnt;
        latch_ops = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;

        case (state)
            IDLE: begin
                // req_ready depends only on state and flush, never on rsp_ready.
                req_ready = !flush;
                if (req_valid && !flush) begin
                    latch_ops = 1'b1;
                    acc_n     = (req_count == '0) ? req_rd : bop_out;
                    if (req_count > CW'(1)) begin
                        // cnt counts the applications still to do in RUN.
                        cnt_n   = req_count - CW'(1);
                        state_n = RUN;
                    end else begin
                        state_n = DONE;
                    end
                end
            end

            RUN: begin
                if (flush) begin
                    state_n = IDLE;
                end else begin
                    acc_n = bop_out;
                    if (cnt == CW'(1)) begin
                        // Last application; cnt is left at 1 rather than
                        // stepped down to 0.
                        state_n = DONE;
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
            end

            DONE: begin
                rsp_valid = 1'b1;
                // A flush together with rsp_ready still counts as consumed;
                // either way the sequencer returns to IDLE.
                if (flush || rsp_ready) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            lut_q <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            if (latch_ops) begin
                rs1_q <= req_rs1;
                rs2_q <= req_rs2;
                lut_q <= req_lut;
            end
        end
    end

    assign rsp_result = acc;
    assign busy       = (state != IDLE);

endmodule
